// File: rtl/pieo_enq_fifo_tracker.sv
// Purpose: tracks per-flow FIFOs that have a packet waiting but no element in the PIEO, round-robin picks one for pre-enqueue.
// Latency: 1 cycle from any input change (fifo_not_empty, trigger, deq_done) to registered flag/fifo_id/bitmap/count.
// Backpressure: fifo_id/flag hold steady until a trigger or state change; downstream may stall indefinitely without loss.
module pieo_enq_fifo_tracker #(
   parameter int NUM_FIFO = 3,
   parameter int ID_LOG   = 2,
   parameter int CNT_LOG  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_FIFO-1:0] fifo_not_empty,
   input  logic                pieo_enq_trigger,
   input  logic                deq_done,
   input  logic [ID_LOG-1:0]   deq_fifo_id,
   output logic                fifos_not_enq_flag,
   output logic [ID_LOG-1:0]   fifo_id,
   output logic [NUM_FIFO-1:0] in_pieo_bitmap,
   output logic [CNT_LOG-1:0]  in_pieo_count,
   output logic                protocol_error
);

   localparam logic [ID_LOG-1:0] LAST_ID = ID_LOG'(NUM_FIFO - 1);

   // registered state
   logic                flag_q,    flag_d;
   logic [ID_LOG-1:0]   fifo_id_q, fifo_id_d;
   logic [NUM_FIFO-1:0] bitmap_q,  bitmap_d;
   logic [CNT_LOG-1:0]  count_q,   count_d;
   logic [ID_LOG-1:0]   rr_ptr_q,  rr_ptr_d;
   logic                error_q,   error_d;

   // event decode
   logic                legal_trig;
   logic                legal_deq;
   logic                trig_err;
   logic                deq_err;
   logic [NUM_FIFO-1:0] set_vec;
   logic [NUM_FIFO-1:0] clr_vec;

   // selection
   logic [NUM_FIFO-1:0] elig_mask;
   logic                hi_hit;
   logic                lo_hit;
   logic [ID_LOG-1:0]   hi_sel;
   logic [ID_LOG-1:0]   lo_sel;

   // Decode trigger and deq_done into one-hot set/clear vectors; an out-of-range
   // deq id decodes to an empty clear vector and is therefore flagged illegal.
   always_comb begin
      set_vec    = '0;
      clr_vec    = '0;
      legal_trig = pieo_enq_trigger & flag_q;
      for (int i = 0; i < NUM_FIFO; i++) begin
         set_vec[i] = legal_trig && (fifo_id_q == ID_LOG'(i));
         clr_vec[i] = deq_done && (deq_fifo_id == ID_LOG'(i));
      end
      legal_deq = |(clr_vec & bitmap_q);
      trig_err  = pieo_enq_trigger & ~flag_q;
      deq_err   = deq_done & ~legal_deq;
   end

   // Next bitmap, its popcount, and the round-robin pointer advance past the enqueued id.
   always_comb begin
      bitmap_d = (bitmap_q | set_vec) & ~(legal_deq ? clr_vec : '0);
      count_d  = '0;
      for (int i = 0; i < NUM_FIFO; i++) begin
         count_d = count_d + CNT_LOG'(bitmap_d[i]);
      end
      if (legal_trig) begin
         rr_ptr_d = (fifo_id_q == LAST_ID) ? '0 : fifo_id_q + ID_LOG'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Wrapped search from rr_ptr_d: lowest eligible id at or above the pointer,
   // else lowest eligible id overall. Descending scan leaves the lowest match.
   always_comb begin
      elig_mask = fifo_not_empty & ~bitmap_d;
      hi_hit    = 1'b0;
      lo_hit    = 1'b0;
      hi_sel    = '0;
      lo_sel    = '0;
      for (int i = NUM_FIFO - 1; i >= 0; i--) begin
         if (elig_mask[i]) begin
            lo_hit = 1'b1;
            lo_sel = ID_LOG'(i);
            if (ID_LOG'(i) >= rr_ptr_d) begin
               hi_hit = 1'b1;
               hi_sel = ID_LOG'(i);
            end
         end
      end
   end

   // Present the selection; fifo_id holds its last value when nothing is eligible.
   always_comb begin
      flag_d    = hi_hit | lo_hit;
      fifo_id_d = fifo_id_q;
      if (hi_hit) begin
         fifo_id_d = hi_sel;
      end else if (lo_hit) begin
         fifo_id_d = lo_sel;
      end
      error_d = error_q | trig_err | deq_err;
   end

   // State registers with synchronous active-low reset taking priority over all events.
   always_ff @(posedge clk) begin
      if (!rst) begin
         flag_q    <= 1'b0;
         fifo_id_q <= '0;
         bitmap_q  <= '0;
         count_q   <= '0;
         rr_ptr_q  <= '0;
         error_q   <= 1'b0;
      end else begin
         flag_q    <= flag_d;
         fifo_id_q <= fifo_id_d;
         bitmap_q  <= bitmap_d;
         count_q   <= count_d;
         rr_ptr_q  <= rr_ptr_d;
         error_q   <= error_d;
      end
   end

   assign fifos_not_enq_flag = flag_q;
   assign fifo_id            = fifo_id_q;
   assign in_pieo_bitmap     = bitmap_q;
   assign in_pieo_count      = count_q;
   assign protocol_error     = error_q;

endmodule

// File: tb/tb_pieo_enq_fifo_tracker.sv
// Purpose: self-checking bench for pieo_enq_fifo_tracker: directed vector table plus randomized traffic against a reference model.
// Latency: every stimulus row is applied for one clock and outputs are sampled 1 time unit after that edge.
// Backpressure: trigger is withheld at random to model a stalling pre-enqueue stage.
module tb_pieo_enq_fifo_tracker;

   localparam int N   = 3;
   localparam int IDW = 2;
   localparam int CW  = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   ne;
   logic           trig;
   logic           deq;
   logic [IDW-1:0] did;
   logic           flag;
   logic [IDW-1:0] fid;
   logic [N-1:0]   bm;
   logic [CW-1:0]  cnt;
   logic           perr;

   always #5 clk = ~clk;

   pieo_enq_fifo_tracker #(.NUM_FIFO(N), .ID_LOG(IDW), .CNT_LOG(CW)) dut (
      .clk                (clk),
      .rst                (rst),
      .fifo_not_empty     (ne),
      .pieo_enq_trigger   (trig),
      .deq_done           (deq),
      .deq_fifo_id        (did),
      .fifos_not_enq_flag (flag),
      .fifo_id            (fid),
      .in_pieo_bitmap     (bm),
      .in_pieo_count      (cnt),
      .protocol_error     (perr)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Reference model: per-FIFO "in PIEO" flags, round-robin start point,
   // currently presented id/flag, sticky error.
   bit m_in [N];
   int m_rr;
   bit m_flag;
   int m_id;
   bit m_err;

   function void model_step(bit r, bit [N-1:0] ne_i, bit tr, bit dq, int dqid);
      bit release_ok;
      bit found;
      if (!r) begin
         foreach (m_in[j]) m_in[j] = 1'b0;
         m_rr = 0; m_flag = 1'b0; m_id = 0; m_err = 1'b0;
         return;
      end
      release_ok = 1'b0;
      if (dq) begin
         if (dqid >= N) m_err = 1'b1;
         else if (!m_in[dqid]) m_err = 1'b1;
         else release_ok = 1'b1;
      end
      if (tr) begin
         if (!m_flag) m_err = 1'b1;
         else begin
            m_in[m_id] = 1'b1;
            m_rr = (m_id + 1) % N;
         end
      end
      if (release_ok) m_in[dqid] = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_rr + k) % N;
         if (!found && ne_i[j] && !m_in[j]) begin
            found = 1'b1;
            m_id  = j;
         end
      end
      m_flag = found;
   endfunction

   task automatic apply(input bit r, input bit [N-1:0] n, input bit t, input bit d, input bit [IDW-1:0] id);
      rst = r; ne = n; trig = t; deq = d; did = id;
      @(posedge clk);
      model_step(r, n, t, d, int'(id));
      #1;
   endtask

   typedef struct {
      bit           rst;
      bit [N-1:0]   ne;
      bit           trig;
      bit           deq;
      bit [IDW-1:0] did;
      bit           flag;
      bit [IDW-1:0] id;
      bit [N-1:0]   bm;
      bit [CW-1:0]  cnt;
      bit           err;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl [NV];

   initial begin
      //          rst  ne      trg  deq  did    flag id     bm      cnt    err
      tbl[0]  = '{1'b0, 3'b101, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 2'd0, 1'b0};
      tbl[1]  = '{1'b1, 3'b101, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 3'b000, 2'd0, 1'b0};
      tbl[2]  = '{1'b1, 3'b101, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 3'b000, 2'd0, 1'b0};
      tbl[3]  = '{1'b1, 3'b101, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 3'b001, 2'd1, 1'b0};
      tbl[4]  = '{1'b1, 3'b101, 1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 3'b101, 2'd2, 1'b0};
      tbl[5]  = '{1'b1, 3'b101, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 3'b101, 2'd2, 1'b0};
      tbl[6]  = '{1'b1, 3'b101, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 3'b100, 2'd1, 1'b0};
      tbl[7]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 3'b100, 2'd1, 1'b0};
      tbl[8]  = '{1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 3'b101, 2'd2, 1'b0};
      tbl[9]  = '{1'b1, 3'b111, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 3'b011, 2'd2, 1'b0};
      tbl[10] = '{1'b1, 3'b111, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 3'b110, 2'd2, 1'b0};
      tbl[11] = '{1'b1, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 3'b101, 2'd2, 1'b0};
      tbl[12] = '{1'b1, 3'b111, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 3'b011, 2'd2, 1'b0};
      tbl[13] = '{1'b1, 3'b111, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 3'b001, 2'd1, 1'b0};
      tbl[14] = '{1'b1, 3'b111, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 3'b001, 2'd1, 1'b1};
      tbl[15] = '{1'b1, 3'b111, 1'b0, 1'b1, 2'd3, 1'b1, 2'd2, 3'b001, 2'd1, 1'b1};
      tbl[16] = '{1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 3'b101, 2'd2, 1'b1};
      tbl[17] = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 2'd0, 1'b0};
      tbl[18] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 3'b000, 2'd0, 1'b0};
      tbl[19] = '{1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 2'd0, 1'b0};
      tbl[20] = '{1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 2'd0, 1'b1};
      tbl[21] = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 2'd0, 1'b0};
      tbl[22] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 3'b000, 2'd0, 1'b0};
      tbl[23] = '{1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 3'b001, 2'd1, 1'b0};
      tbl[24] = '{1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 3'b011, 2'd2, 1'b0};
      tbl[25] = '{1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 3'b111, 2'd3, 1'b0};
      tbl[26] = '{1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 3'b111, 2'd3, 1'b1};

      rst = 1'b0; ne = '0; trig = 1'b0; deq = 1'b0; did = '0;

      // Directed vectors
      for (int i = 0; i < NV; i++) begin
         apply(tbl[i].rst, tbl[i].ne, tbl[i].trig, tbl[i].deq, tbl[i].did);
         chk($sformatf("vec%0d flag", i),   int'(flag), int'(tbl[i].flag));
         chk($sformatf("vec%0d fifo_id", i), int'(fid), int'(tbl[i].id));
         chk($sformatf("vec%0d bitmap", i), int'(bm),   int'(tbl[i].bm));
         chk($sformatf("vec%0d count", i),  int'(cnt),  int'(tbl[i].cnt));
         chk($sformatf("vec%0d error", i),  int'(perr), int'(tbl[i].err));
      end

      // Randomized traffic against the reference model
      begin
         bit [N-1:0]   r_ne;
         r_ne = '1;
         for (int c = 0; c < 800; c++) begin
            bit           r_rst;
            bit           r_trig;
            bit           r_deq;
            bit [IDW-1:0] r_id;
            bit [N-1:0]   exp_bm;
            int           exp_cnt;
            int           busy [$];
            r_rst = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 3) == 0) r_ne = N'($urandom_range(0, (1 << N) - 1));
            r_trig = m_flag ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            r_deq  = ($urandom_range(0, 2) == 0);
            busy.delete();
            for (int j = 0; j < N; j++) if (m_in[j]) busy.push_back(j);
            if ($urandom_range(0, 19) == 0 || busy.size() == 0)
               r_id = IDW'($urandom_range(0, (1 << IDW) - 1));
            else
               r_id = IDW'(busy[$urandom_range(0, busy.size() - 1)]);
            apply(r_rst, r_ne, r_trig, r_deq, r_id);
            exp_cnt = 0;
            for (int j = 0; j < N; j++) begin
               exp_bm[j] = m_in[j];
               exp_cnt  += int'(m_in[j]);
            end
            chk($sformatf("rnd%0d flag", c),   int'(flag), int'(m_flag));
            if (m_flag) chk($sformatf("rnd%0d fifo_id", c), int'(fid), m_id);
            chk($sformatf("rnd%0d bitmap", c), int'(bm),   int'(exp_bm));
            chk($sformatf("rnd%0d count", c),  int'(cnt),  exp_cnt);
            chk($sformatf("rnd%0d error", c),  int'(perr), int'(m_err));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pieo_enq_fifo_tracker.md
Name: pieo_enq_fifo_tracker

Overview:
- Upstream neighbour of the PIEO pre-enqueue (min-rate) stage.
- Tracks which per-flow FIFOs have a packet waiting but no element currently in the PIEO.
- Round-robin selects one such FIFO and presents it as fifos_not_enq_flag / fifo_id to the pre-enqueue stage.
- Marks a FIFO in-PIEO on enqueue, and releases it when the PIEO-dequeued packet of that FIFO has been transmitted.

Parameters:
- NUM_FIFO, 3, number of flow FIFOs (need not be a power of 2)
- ID_LOG, 2, width of FIFO id; 2^ID_LOG >= NUM_FIFO
- CNT_LOG, 2, width of in-PIEO occupancy count; 2^CNT_LOG > NUM_FIFO

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-low reset
- fifo_not_empty  in  NUM_FIFO  bit i high when FIFO i holds at least one packet
- pieo_enq_trigger  in  1  from pre-enqueue stage; element for fifo_id accepted this cycle
- deq_done  in  1  pulse: head packet of deq_fifo_id fully transmitted
- deq_fifo_id  in  ID_LOG  FIFO id for deq_done
- fifos_not_enq_flag  out  1  registered; a FIFO is eligible for enqueue
- fifo_id  out  ID_LOG  registered; selected eligible FIFO, valid when flag high
- in_pieo_bitmap  out  NUM_FIFO  registered; bit i high while FIFO i has an element in PIEO or in transmit
- in_pieo_count  out  CNT_LOG  registered; popcount of in_pieo_bitmap
- protocol_error  out  1  sticky error flag

Behaviour:
- Reset (rst=0 at edge):
  - All outputs are 0, round-robin pointer rr_ptr = 0.
  - Reset has priority over every other event.
  - Reset asserted mid-operation discards all tracking; after reset, FIFOs reappear as eligible from fifo_not_empty alone.
- Per-FIFO state:
  - IDLE (bit=0) -> INPIEO (bit=1) on pieo_enq_trigger with fifo_id=i while fifos_not_enq_flag=1.
  - INPIEO -> IDLE on deq_done with deq_fifo_id=i.
- Next-state bitmap: set from the trigger and clear from deq_done, both applied at the same edge. Set and clear can never target the same id legally.
- Next-state eligibility mask: fifo_not_empty & ~bitmap_next.
- Selection:
  - Search the mask starting at rr_ptr_next, ascending, wrapping from NUM_FIFO-1 to 0. The first hit is registered into fifo_id with flag=1.
  - No hit: flag=0 and fifo_id holds its previous value.
- rr_ptr update: on a legal trigger, rr_ptr <= (fifo_id==NUM_FIFO-1) ? 0 : fifo_id+1. Otherwise rr_ptr holds.
- Latency: 1 cycle from any input change (fifo_not_empty, trigger, deq_done) to the updated flag/fifo_id.
  - The FIFO just enqueued is never re-presented in the following cycle.
- Handshake: fifo_id/flag are stable until a trigger or state change. The downstream stage may hold off (pieo_ready low) indefinitely without loss.
- in_pieo_count is registered alongside the bitmap and always equals popcount(in_pieo_bitmap).
- Errors: protocol_error sets and stays set until reset. The offending event has no other effect. Error cases:
  - trigger while flag=0;
  - deq_done for an IDLE FIFO;
  - deq_done with deq_fifo_id >= NUM_FIFO.
- Boundaries:
  - All FIFOs INPIEO: flag=0 and count=NUM_FIFO.
  - Legal trigger and deq_done in the same cycle (different ids): both applied; count unchanged.
  - deq_done for FIFO i while fifo_not_empty[i]=1: FIFO i is eligible at the next edge, subject to the round-robin order.

Test Plan:
- Reset release, fifo_not_empty=3'b101, no trigger -> one cycle later flag=1, fifo_id=0, bitmap=000, count=0; holds while no trigger.
- Trigger with fifo_id=0 -> next cycle fifo_id=2, flag=1, bitmap=001, count=1. Then trigger id 2 -> flag=0, bitmap=101, count=2, rr_ptr=0.
- From previous state, deq_done id 0 with fifo_not_empty[0]=1 -> next cycle flag=1, fifo_id=0, bitmap=100, count=1.
- Same-cycle trigger id 1 and deq_done id 2 (bitmap 101, not_empty=111) -> bitmap=011, count=2, fifo_id=2 next cycle.
- Pointer wrap: all non-empty, trigger ids 2 -> 0 -> 1 in sequence with deq_done releasing each FIFO after its trigger -> fifo_id presented in order 2,0,1,2 (round robin, no starvation).
- Errors: deq_done id 1 while IDLE -> protocol_error=1, bitmap unchanged. deq_done id 3 (NUM_FIFO=3) -> error stays 1. Assert rst=0 mid-traffic -> all outputs 0 next cycle.
